program_loader: RTL and testbench

Switch-driven program loader for the ARMAria board. It writes 16-bit Thumb-style instruction words, entered on the 16 slide switches, into the instruction port of the external memory. It is the writer counterpart of the fetch path that reads `PreInstruction`. While a load session is active it holds the processor, and it releases the processor when the operator presses the end key.

---
 rtl/program_loader.sv | 183 ++++++++++++++++++
 tb/tb_program_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader
//
// Switch-driven program loader. While a load session is open the processor is
// held, and every debounced press of the load key writes the 16-bit word on the
// slide switches into the next instruction address. The end key closes the
// session and releases the processor.
//
// Ports
//   clock      system clock, rising edge
//   reset      synchronous, active-high
//   start      one-cycle pulse, opens a session (already debounced)
//   sw         instruction word to write
//   load_key   raw active-high pushbutton, writes sw
//   end_key    raw active-high pushbutton, closes the session
//   mem_we     write strobe to instruction memory
//   mem_addr   write address
//   mem_wdata  write data
//   cpu_hold   high while a session is open
//   done       one-cycle pulse when the session closes
//   count      words written in the current or last session
//   overflow   sticky: a write was refused because memory was full
module program_loader #(
  parameter int ADDR_WIDTH      = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           sw,
  input  logic                  load_key,
  input  logic                  end_key,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  // The counter only ever holds 0 .. DEBOUNCE_CYCLES-2.
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES - 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Key index 0 is load, index 1 is end.
  logic [1:0]    keys;
  logic [1:0]    sync1_q, sync1_d;
  logic [1:0]    sync2_q, sync2_d;
  logic [1:0]    level_q, level_d;
  logic [1:0]    press_q, press_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_t                state_q, state_d;
  logic                  pend_load_q, pend_load_d;
  logic                  pend_end_q, pend_end_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  end_evt;

  assign keys = {end_key, load_key};

  // Stage: key synchronizer and debounce
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sync1_d[k] = keys[k];
      sync2_d[k] = sync1_q[k];
      level_d[k] = level_q[k];
      press_d[k] = 1'b0;
      cnt_d[k]   = '0;
      // Count consecutive cycles where the synchronized level disagrees with
      // the accepted one; any agreement restarts the count.
      if (sync2_q[k] != level_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          level_d[k] = ~level_q[k];
          press_d[k] = ~level_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Stage: session FSM
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    // A load press is always served one cycle after its event; holding it
    // through WRITE keeps a press that lands in the write cycle.
    pend_load_d = press_q[0] | (pend_load_q & (state_q == WRITE));
    // End acts directly on its event, so only a press during WRITE is parked.
    pend_end_d  = press_q[1] & (state_q == WRITE);
    end_evt     = press_q[1] | pend_end_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ARMED: begin
        if (end_evt) begin
          state_d = FINISH;
        end else if (pend_load_q) begin
          // count's top bit set means every address has been written.
          if (count_q[ADDR_WIDTH]) begin
            ovf_d = 1'b1;
          end else begin
            wdata_d = sw;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d  = addr_q + 1'b1;
        count_d = count_q + 1'b1;
        state_d = ARMED;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      press_q     <= '0;
      cnt_q[0]    <= '0;
      cnt_q[1]    <= '0;
      state_q     <= IDLE;
      pend_load_q <= 1'b0;
      pend_end_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      cnt_q[0]    <= cnt_d[0];
      cnt_q[1]    <= cnt_d[1];
      state_q     <= state_d;
      pend_load_q <= pend_load_d;
      pend_end_q  <= pend_end_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
    end
  end

  // Stage: outputs, decoded from registered state only
  assign mem_we    = (state_q == WRITE);
  assign cpu_hold  = (state_q == ARMED) || (state_q == WRITE);
  assign done      = (state_q == FINISH);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

  localparam int AW = 3;
  localparam int DC = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   sw = '0;
  logic          load_key = 1'b0;
  logic          end_key = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic [AW:0]   count;
  logic          overflow;

  program_loader #(.ADDR_WIDTH(AW), .DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock), .reset(reset), .start(start), .sw(sw),
    .load_key(load_key), .end_key(end_key),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .count(count), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int we_total   = 0;
  int done_total = 0;
  int hold_total = 0;
  int last_addr  = -1;
  int last_data  = -1;
  int last_wcyc  = -1;
  logic hold_at_done = 1'b1;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (mem_we) begin
      we_total++;
      last_addr = int'(mem_addr);
      last_data = int'(mem_wdata);
      last_wcyc = cyc;
    end
    if (done) begin
      done_total++;
      hold_at_done = cpu_hold;
    end
    if (cpu_hold) hold_total++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic press_load(input logic [15:0] val);
    sw = val;
    load_key = 1'b1;
    tick(10);
    load_key = 1'b0;
    tick(10);
  endtask

  task automatic press_end();
    end_key = 1'b1;
    tick(10);
    end_key = 1'b0;
    tick(10);
  endtask

  typedef struct {
    logic [15:0] sw_val;
    int          exp_we;
    int          exp_addr;
    int          exp_count;
    int          exp_ovf;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int we0, done0, hold0, t0;
    logic [9:0] bounce;
    bit found;

    // Full-memory table: nine presses into an 8-word memory.
    for (int i = 0; i < 9; i++) begin
      vecs[i].sw_val    = 16'(i);
      vecs[i].exp_we    = (i < 8) ? 1 : 0;
      vecs[i].exp_addr  = (i < 8) ? i : 7;
      vecs[i].exp_count = (i < 8) ? i + 1 : 8;
      vecs[i].exp_ovf   = (i < 8) ? 0 : 1;
    end

    // Reset state
    tick(3);
    @(negedge clock);
    check("rst_we", int'(mem_we), 0);
    check("rst_hold", int'(cpu_hold), 0);
    check("rst_done", int'(done), 0);
    check("rst_count", int'(count), 0);
    check("rst_ovf", int'(overflow), 0);
    check("rst_addr", int'(mem_addr), 0);
    reset = 1'b0;
    tick(2);

    // Idle keys: nothing happens outside a session
    we0 = we_total; done0 = done_total; hold0 = hold_total;
    press_load(16'hBEEF);
    press_end();
    check("idle_we", we_total - we0, 0);
    check("idle_done", done_total - done0, 0);
    check("idle_hold", hold_total - hold0, 0);

    // Basic load with latency check
    pulse_start();
    check("armed_hold", int'(cpu_hold), 1);
    we0 = we_total;
    t0 = cyc;
    press_load(16'h2005);
    check("basic1_n", we_total - we0, 1);
    check("basic1_lat", last_wcyc - t0, DC + 3);
    check("basic1_addr", last_addr, 0);
    check("basic1_data", last_data, 16'h2005);
    press_load(16'h4288);
    check("basic2_n", we_total - we0, 2);
    check("basic2_addr", last_addr, 1);
    check("basic2_data", last_data, 16'h4288);
    check("basic_count", int'(count), 2);
    check("basic_hold", int'(cpu_hold), 1);

    // Bounce: one write from a bouncy press, none from a short glitch
    we0 = we_total;
    sw = 16'h1111;
    bounce = 10'b1111110101;
    for (int i = 0; i < 10; i++) begin
      load_key = bounce[i];
      tick(1);
    end
    load_key = 1'b0;
    tick(12);
    check("bounce_n", we_total - we0, 1);
    check("bounce_addr", last_addr, 2);
    check("bounce_data", last_data, 16'h1111);
    load_key = 1'b1;
    tick(2);
    load_key = 1'b0;
    tick(12);
    check("glitch_n", we_total - we0, 1);
    check("glitch_count", int'(count), 3);

    // Close the session
    done0 = done_total;
    press_end();
    check("end_done", done_total - done0, 1);
    check("end_hold_at_done", int'(hold_at_done), 0);
    check("end_hold", int'(cpu_hold), 0);
    check("end_count_kept", int'(count), 3);

    // Full memory, table driven
    pulse_start();
    check("full_count0", int'(count), 0);
    for (int i = 0; i < 9; i++) begin
      we0 = we_total;
      press_load(vecs[i].sw_val);
      check($sformatf("full%0d_we", i), we_total - we0, vecs[i].exp_we);
      check($sformatf("full%0d_addr", i), last_addr, vecs[i].exp_addr);
      check($sformatf("full%0d_data", i), last_data, vecs[i].exp_addr);
      check($sformatf("full%0d_count", i), int'(count), vecs[i].exp_count);
      check($sformatf("full%0d_ovf", i), int'(overflow), vecs[i].exp_ovf);
    end
    press_end();
    check("full_ovf_kept", int'(overflow), 1);

    // End priority over a simultaneous load press
    pulse_start();
    check("prio_ovf_clr", int'(overflow), 0);
    we0 = we_total; done0 = done_total;
    hold_at_done = 1'b1;
    sw = 16'h5A5A;
    load_key = 1'b1;
    end_key  = 1'b1;
    tick(10);
    load_key = 1'b0;
    end_key  = 1'b0;
    tick(10);
    check("prio_we", we_total - we0, 0);
    check("prio_done", done_total - done0, 1);
    check("prio_hold_at_done", int'(hold_at_done), 0);
    check("prio_count", int'(count), 0);

    // Reset asserted in the WRITE cycle
    pulse_start();
    sw = 16'hAAAA;
    load_key = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clock);
      if (mem_we) found = 1'b1;
    end
    check("midrst_we_seen", int'(found), 1);
    reset = 1'b1;
    load_key = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midrst_we", int'(mem_we), 0);
    check("midrst_hold", int'(cpu_hold), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_addr", int'(mem_addr), 0);
    check("midrst_wdata", int'(mem_wdata), 0);
    check("midrst_ovf", int'(overflow), 0);
    tick(2);
    reset = 1'b0;
    tick(3);
    pulse_start();
    we0 = we_total;
    press_load(16'h1234);
    check("restart_n", we_total - we0, 1);
    check("restart_addr", last_addr, 0);
    check("restart_data", last_data, 16'h1234);
    check("restart_count", int'(count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
